// File: rtl/irom_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package irom_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_HI,
    ST_HDR_LO,
    ST_DATA,
    ST_CSUM,
    ST_RUN,
    ST_ERR
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;
  localparam int unsigned CNT_W          = 10;
  localparam logic [7:0]  CSUM_RESIDUE   = 8'h00;

  // States in which the loader consumes bytes from the stream.
  function automatic logic accepts_bytes(input state_t s);
    return (s == ST_HDR_HI) || (s == ST_HDR_LO) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/irom_loader_if.sv
// Loader bundle: byte-stream handshake, instruction-memory write port and
// boot status. The master modport is the loader side.
interface irom_loader_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              proc_rst_n;
  logic              load_done;
  logic              load_err;

  modport master (
    input  start, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, proc_rst_n, load_done, load_err
  );

  modport slave (
    output start, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, proc_rst_n, load_done, load_err
  );
endinterface

// File: rtl/irom_loader_byte_word_packer.sv
// Big-endian byte-to-word assembler: shifts bytes in MSB first and pulses
// word_valid_o for one cycle, the cycle after the last byte of a word.
module byte_word_packer
  import irom_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o,
  output logic [1:0]        byte_cnt_o
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [WORD_W-1:0] word_q, word_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic              word_valid_q, word_valid_d;

  // Next-state: shift in accepted bytes, flag completion of a word.
  always_comb begin
    word_d       = word_q;
    byte_cnt_d   = byte_cnt_q;
    word_valid_d = 1'b0;
    if (clr_i) begin
      byte_cnt_d = '0;
    end else if (byte_valid_i) begin
      word_d       = {word_q[WORD_W-9:0], byte_i};
      byte_cnt_d   = byte_cnt_q + 2'd1;
      word_valid_d = (byte_cnt_q == LAST_BYTE);
    end
  end

  // Packer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q       <= '0;
      byte_cnt_q   <= '0;
      word_valid_q <= 1'b0;
    end else begin
      word_q       <= word_d;
      byte_cnt_q   <= byte_cnt_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = word_valid_q;
  assign byte_cnt_o   = byte_cnt_q;

endmodule

// File: rtl/irom_loader.sv
// Boot loader: parses a counted, checksummed byte frame, writes the words
// into instruction memory from address 0, and releases the processor reset
// only after the image has been verified.
module irom_loader
  import irom_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEPTH  = 512
) (
  input logic           clk,
  input logic           rst,
  irom_loader_if.master bus
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_t             state_q, state_d;
  logic [1:0]         cnt_hi_q, cnt_hi_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [7:0]         xor_q, xor_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic               in_ready_q, proc_rst_n_q, load_done_q, load_err_q;

  logic               xfer, data_xfer, word_last_byte, load_begin;
  logic [CNT_W-1:0]   hdr_count;
  logic [WORD_W-1:0]  pk_word;
  logic               pk_word_valid;
  logic [1:0]         pk_byte_cnt;

  assign xfer           = bus.in_valid && in_ready_q;
  assign data_xfer      = xfer && (state_q == ST_DATA);
  assign word_last_byte = data_xfer && (pk_byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign load_begin     = bus.start &&
                          ((state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_ERR));
  assign hdr_count      = {cnt_hi_q, bus.in_data};

  byte_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (load_begin),
    .byte_valid_i (data_xfer),
    .byte_i       (bus.in_data),
    .word_o       (pk_word),
    .word_valid_o (pk_word_valid),
    .byte_cnt_o   (pk_byte_cnt)
  );

  // Next-state logic: frame parsing, word indexing and checksum folding.
  always_comb begin
    state_d    = state_q;
    cnt_hi_d   = cnt_hi_q;
    count_d    = count_q;
    word_cnt_d = word_cnt_q;
    xor_d      = xor_q;
    wr_addr_d  = wr_addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_HDR_HI;
      end
      ST_HDR_HI: begin
        if (xfer) begin
          cnt_hi_d = bus.in_data[1:0];
          state_d  = ST_HDR_LO;
        end
      end
      ST_HDR_LO: begin
        if (xfer) begin
          count_d = hdr_count;
          if ((hdr_count == '0) || (hdr_count > DEPTH_C)) state_d = ST_ERR;
          else                                            state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          xor_d = xor_q ^ bus.in_data;
          if (word_last_byte) begin
            // Address is latched alongside the packer's word so the write
            // strobe, address and data all appear together next cycle.
            wr_addr_d  = word_cnt_q[ADDR_W-1:0];
            word_cnt_d = word_cnt_q + ONE_C;
            if (word_cnt_q == count_q - ONE_C) state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (xfer) begin
          if ((xor_q ^ bus.in_data) == CSUM_RESIDUE) state_d = ST_RUN;
          else                                       state_d = ST_ERR;
        end
      end
      ST_RUN, ST_ERR: begin
        if (bus.start) state_d = ST_HDR_HI;
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_begin) begin
      word_cnt_d = '0;
      xor_d      = '0;
    end
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_hi_q     <= '0;
      count_q      <= '0;
      word_cnt_q   <= '0;
      xor_q        <= '0;
      wr_addr_q    <= '0;
      in_ready_q   <= 1'b0;
      proc_rst_n_q <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_hi_q     <= cnt_hi_d;
      count_q      <= count_d;
      word_cnt_q   <= word_cnt_d;
      xor_q        <= xor_d;
      wr_addr_q    <= wr_addr_d;
      in_ready_q   <= accepts_bytes(state_d);
      proc_rst_n_q <= (state_d == ST_RUN);
      load_done_q  <= (state_d == ST_RUN);
      load_err_q   <= (state_d == ST_ERR);
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.wr_en      = pk_word_valid;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = pk_word;
  assign bus.proc_rst_n = proc_rst_n_q;
  assign bus.load_done  = load_done_q;
  assign bus.load_err   = load_err_q;

endmodule
